uart_rx_buf: RTL and testbench
==============================

UART_RX_BUF -- requirements
Module: uart_rx_buf

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clocks per UART bit period, legal range 8..2047.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive buffer entries, power of two, 2..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. All logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset. It is asynchronous and active-high.
REQ-005 SHALL have port rx, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port rx_data, output, 8 bits: oldest buffered byte.
REQ-007 SHALL have port rx_valid, output, 1 bit: buffer is non-empty.
REQ-008 SHALL have port rx_ready, input, 1 bit: consumer accepts rx_data.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit samples 0.
REQ-010 SHALL have port overrun, output, 1 bit: one-cycle pulse when a good byte is dropped because the buffer is full.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer to give rx_s; both flops reset to 1.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and WAIT_HIGH, with a bit counter cnt of 11 bits.
REQ-014 SHALL, in IDLE, go to START with cnt=0 when rx_s==0.
REQ-015 SHALL, in START, sample rx_s at cnt==CLKS_PER_BIT/2-1: if 1 (false start), go to IDLE silently; if 0, set cnt=0 and go to DATA.
REQ-016 SHALL, in DATA, sample rx_s at each cnt==CLKS_PER_BIT-1 and reset cnt, shifting bits LSB-first; after 8 bits go to PARITY if the macro is defined, else STOP.
REQ-017 SHALL, in STOP, sample at cnt==CLKS_PER_BIT-1: if 1, push the byte and go to IDLE; if 0, pulse frame_err, discard the byte and go to WAIT_HIGH.
REQ-018 SHALL leave WAIT_HIGH for IDLE only on rx_s==1, so that a break condition does not produce repeated frames.
REQ-019 SHALL make rx_valid rise on the cycle after the stop-bit sample when the buffer was empty.
REQ-020 SHALL present rx_data from the head entry while rx_valid is high.
REQ-021 SHALL pop the head entry on the cycle where rx_valid && rx_ready.
REQ-022 SHALL keep rx_data stable while rx_valid is high and rx_ready is low.
REQ-023 SHALL, on a push while full with no pop, drop the new byte, pulse overrun and leave the buffer contents unchanged.
REQ-024 SHALL, on a push and pop in the same cycle while full, perform both, leave the count unchanged and not pulse overrun.
REQ-025 SHALL, on a push and pop in the same cycle while empty, not occur, because rx_valid is 0 when empty.
REQ-026 SHALL wrap read/write pointers modulo FIFO_DEPTH and keep a count of width log2(FIFO_DEPTH)+1.

Reset
REQ-027 SHALL, while rst is high, immediately force the state: FSM=IDLE, cnt=0, buffer empty, rx_valid=0, rx_data=0, frame_err=0, overrun=0, busy=0, parity_err=0, synchronizer flops=1.
REQ-028 SHALL, when rst is asserted mid-frame, abandon the partial byte; reception restarts on the next start bit after release.

Configuration
REQ-029 SHALL, with UART_RX_PARITY_EN defined, expect an even-parity bit after the data bits, sampled in PARITY at cnt==CLKS_PER_BIT-1.
REQ-030 SHALL, with UART_RX_PARITY_EN defined, on parity mismatch pulse output parity_err (1 bit) for one cycle and still check the stop bit, but never push the byte.
REQ-031 SHALL, without UART_RX_PARITY_EN, have no PARITY state and no parity_err port; the frame is 8N1.

Structure
REQ-032 SHALL place the FSM state encoding, DEFAULT_CLKS_PER_BIT=16 and UART_DATA_BITS=8 in shared package uart_pkg.
REQ-033 SHALL implement the buffer as sub-module uart_rx_fifo, a synchronous show-ahead FIFO with push, pop, full, empty and count.

Verification
REQ-034 SHALL cover: frames 0x68, 0x69, 0x21 with rx_ready=1 -> three rx_valid cycles carrying 0x68, 0x69, 0x21, with no frame_err or overrun.
REQ-035 SHALL cover: rx_ready=0 while 5 frames 0x01..0x05 arrive -> overrun pulses once on 0x05; draining then yields 0x01..0x04 and rx_valid drops.
REQ-036 SHALL cover: 0x55 with stop bit 0, line then held low for 30 bit times -> exactly one frame_err, no push, busy held; after the line goes high, 0xAA is received correctly.
REQ-037 SHALL cover: a 4-clock low glitch on rx -> no push, no error, FSM back in IDLE within CLKS_PER_BIT/2+3 cycles.
REQ-038 SHALL cover: rst asserted during bit 3 of 0x3C -> all outputs 0 in the same cycle; the next frame 0xC3 is received correctly.
REQ-039 SHALL cover, with UART_RX_PARITY_EN: 0x07 sent with parity bit 0 -> parity_err pulses, no push; 0x07 sent with parity bit 1 -> rx_data=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Build option: UART_RX_PARITY_EN adds an even-parity bit to each frame.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int UART_DATA_BITS = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: head entry is visible on rdata while non-empty.
// A push while full only lands if a pop frees a slot in the same cycle.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_q];
  assign count   = cnt_q;

  // Pointer, storage and occupancy update.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_buf.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a small FIFO.
// Framing errors park the FSM until the line returns high (break-safe).
module uart_rx_buf
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun,
`ifdef UART_RX_PARITY_EN
  output logic                      parity_err,
`endif
  output logic                      busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [10:0] BIT_M1  = 11'(CLKS_PER_BIT - 1);
  localparam logic [10:0] HALF_M1 = 11'(CLKS_PER_BIT / 2 - 1);

  logic        rx_meta_q, rx_s_q;
  rx_state_e   state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;
  logic        push_req;
  logic        pop;
  logic        fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [UART_DATA_BITS-1:0] fifo_rdata;
`ifdef UART_RX_PARITY_EN
  logic        pbad_q, pbad_d;
  logic        pe_q, pe_d;
`endif

  // Two-flop synchronizer; idle-high reset avoids a false start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame decoder: next state, bit timing, byte assembly and push.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 11'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fe_d     = 1'b0;
    push_req = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d   = pbad_q;
    pe_d     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
`ifdef UART_RX_PARITY_EN
        pbad_d = 1'b0;
`endif
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          pbad_d  = (rx_s_q != ^shift_q);
          pe_d    = (rx_s_q != ^shift_q);
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
            push_req = !pbad_q;
`else
            push_req = 1'b1;
`endif
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
    ov_d = push_req && fifo_full && !pop;
  end

  // Decoder state and status pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
      pe_q    <= pe_d;
`endif
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rx_valid  = (fifo_count != '0);
  assign pop       = rx_valid && rx_ready;
  assign rx_data   = fifo_empty ? '0 : fifo_rdata;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed + randomized bench for uart_rx_buf with a queue-based model.
// Parity scenarios are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx_buf;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         pe_cnt = 0;
`endif

  int checks = 0;
  int passes = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vcyc   = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] buf_q[$];

  always #5 clk = ~clk;

  uart_rx_buf #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  // Monitor: records accepted bytes and counts status pulses.
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid) vcyc++;
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line driver; the line is left at the stop-bit level.
  task automatic send(input logic [7:0] b, input logic stop_b);
    rx = 1'b0;
    clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      clks(CPB);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^b;
    clks(CPB);
`endif
    rx = stop_b;
    clks(CPB);
  endtask

  // Compare accepted bytes with the model, then clear both.
  task automatic compare_out(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check(tag, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int fe0;
    int ov0;
    int v0;
    logic [7:0] b;
    logic [7:0] part;

    rst = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    clks(3);
    rst = 1'b0;
    clks(4);

    // Three frames drained immediately.
    rx_ready = 1'b1;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    v0 = vcyc;
    send(8'h68, 1'b1);
    exp_q.push_back(8'h68);
    send(8'h69, 1'b1);
    exp_q.push_back(8'h69);
    send(8'h21, 1'b1);
    exp_q.push_back(8'h21);
    clks(4);
    check("three_vcyc", vcyc - v0, 3);
    check("three_ferr", fe_cnt - fe0, 0);
    check("three_ovr", ov_cnt - ov0, 0);
    compare_out("three");

    // Randomized bytes with random inter-frame gaps.
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send(b, 1'b1);
      exp_q.push_back(b);
      clks($urandom_range(0, 5));
    end
    clks(4);
    compare_out("rand");

    // Stalled consumer: buffer fills, fifth byte overruns.
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    buf_q.delete();
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) check("ovr_before5", ov_cnt - ov0, 0);
      send(8'(i), 1'b1);
      if (buf_q.size() < DEPTH) buf_q.push_back(8'(i));
    end
    clks(4);
    check("ovr_once", ov_cnt - ov0, 5 - DEPTH);
    check("ovr_valid", rx_valid, 1);
    check("ovr_head", rx_data, buf_q[0]);
    clks(CPB);
    check("ovr_stable", rx_data, buf_q[0]);
    rx_ready = 1'b1;
    clks(DEPTH + 2);
    exp_q = buf_q;
    compare_out("drain");
    check("drain_valid", rx_valid, 0);

    // Bad stop bit followed by a long break.
    fe0 = fe_cnt;
    send(8'h55, 1'b0);
    clks(30 * CPB);
    check("brk_ferr", fe_cnt - fe0, 1);
    check("brk_busy", busy, 1);
    check("brk_valid", rx_valid, 0);
    rx = 1'b1;
    clks(4);
    check("brk_idle", busy, 0);
    send(8'hAA, 1'b1);
    exp_q.push_back(8'hAA);
    clks(4);
    compare_out("after_brk");
    check("after_brk_ferr", fe_cnt - fe0, 1);

    // Short glitch is rejected at the start-bit midpoint.
    fe0 = fe_cnt;
    rx = 1'b0;
    clks(4);
    rx = 1'b1;
    check("glitch_seen", busy, 1);
    clks(CPB / 2 + 3 - 4);
    check("glitch_idle", busy, 0);
    clks(2);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", fe_cnt - fe0, 0);

    // Reset mid-frame with a byte already buffered.
    rx_ready = 1'b0;
    send(8'h5A, 1'b1);
    clks(2);
    part = 8'h3C;
    rx = 1'b0;
    clks(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = part[i];
      clks(CPB);
    end
    rx = part[3];
    clks(CPB / 2);
    check("pre_rst_valid", rx_valid, 1);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovr", overrun, 0);
    rx = 1'b1;
    clks(3);
    rst = 1'b0;
    got_q.delete();
    rx_ready = 1'b1;
    clks(CPB);
    send(8'hC3, 1'b1);
    exp_q.push_back(8'hC3);
    clks(4);
    compare_out("post_rst");

`ifdef UART_RX_PARITY_EN
    // Wrong then right parity bit for 0x07 (even parity bit is 1).
    begin
      int pe0;
      logic [8:0] fr;
      pe0 = pe_cnt;
      for (int k = 0; k < 2; k++) begin
        fr = {1'(k), 8'h07};
        rx = 1'b0;
        clks(CPB);
        for (int i = 0; i < 9; i++) begin
          rx = fr[i];
          clks(CPB);
        end
        rx = 1'b1;
        clks(CPB);
        if (k == 0) begin
          clks(2);
          check("par_err", pe_cnt - pe0, 1);
          check("par_nopush", got_q.size(), 0);
        end
      end
      exp_q.push_back(8'h07);
      clks(4);
      check("par_err_total", pe_cnt - pe0, 1);
      compare_out("par_ok");
    end
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
